// File: rtl/buffer_drain_ctr.sv
// Line-buffer priming / drain controller.
// Counts samples into an external line buffer (FILL), passes samples through
// once the buffer is primed (STREAM), and after the last sample of a frame
// flushes the remaining buffer contents (DRAIN). Requires DEPTH <= 2^CW - 1.
module buffer_drain_ctr #(
   parameter int DEPTH = 78,
   parameter int CW    = 7
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic i_valid,
   input  logic i_last,
   output logic o_ready,
   input  logic i_ready,
   output logic o_valid,
   output logic o_last,
   output logic o_shift,
   output logic o_busy
);

   typedef enum logic [1:0] {
      FILL   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } state_t;

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] ONE_C   = CW'(1);

   state_t        state;
   logic [CW-1:0] cnt;

   // Frame logic is live only when out of reset and not being aborted.
   logic active;
   logic accept;
   logic xfer;

   assign active = rst & ~clear;
   assign accept = i_valid & o_ready;
   assign xfer   = o_valid & i_ready;

   // Handshake and shift strobes, decoded from state and squashed by reset/clear.
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // a signal unassigned, which would otherwise infer a latch.
      o_ready = 1'b0;
      o_valid = 1'b0;
      o_last  = 1'b0;
      o_shift = 1'b0;
      if (active) begin
         case (state)
            FILL: begin
               o_ready = 1'b1;
               o_shift = i_valid;
            end
            STREAM: begin
               // Input and output move together, so ready/valid pass straight through.
               o_ready = i_ready;
               o_valid = i_valid;
               o_shift = i_valid & i_ready;
            end
            DRAIN: begin
               o_valid = 1'b1;
               o_last  = (cnt == ONE_C);
               o_shift = i_ready;
            end
            default: ;
         endcase
      end
   end

   // State and occupancy counter; reset and clear both abandon the frame.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!rst || clear) begin
         state <= FILL;
         cnt   <= '0;
      end else begin
         case (state)
            FILL: begin
               if (accept) begin
                  cnt <= cnt + ONE_C;
                  if (i_last) begin
                     // Short frame: drain exactly what has been buffered so far.
                     state <= DRAIN;
                  end else if (cnt == DEPTH_C - ONE_C) begin
                     state <= STREAM;
                  end
               end
            end
            STREAM: begin
               // cnt stays at DEPTH; the last sample's own transfer precedes the flush.
               if (xfer && i_last) begin
                  state <= DRAIN;
                  cnt   <= DEPTH_C;
               end
            end
            DRAIN: begin
               if (xfer) begin
                  if (cnt == ONE_C) begin
                     state <= FILL;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt - ONE_C;
                  end
               end
            end
            default: begin
               state <= FILL;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign o_busy = (cnt != '0) | (state == DRAIN);

endmodule
